// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped switch/LED block: register
// offsets inside the 4-word window, switch count and default base address.
package gpio_pkg;

  localparam int          NUM_SW        = 10;
  localparam logic [15:0] DEF_BASE_ADDR = 16'hC000;

  localparam logic [1:0] LED_OFS  = 2'd0;
  localparam logic [1:0] SW_OFS   = 2'd1;
  localparam logic [1:0] EDGE_OFS = 2'd2;
  localparam logic [1:0] MASK_OFS = 2'd3;

  // True when addr falls in the 4-word window starting at base (base is word-aligned to 4).
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:2] == base[15:2];
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit switch conditioner: two-flop synchronizer, hold counter and
// debounced output. 'changed' is high during the cycle whose rising edge
// will flip sw_deb, so the parent can set its edge flag on that same edge.
module gpio_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_deb,
  output logic changed
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic        sync_meta;
  logic        sync_q;
  logic [15:0] cnt;

  assign changed = (sync_q != sw_deb) && (cnt == DB_LAST);

  // Bring the asynchronous switch into the clk domain before anything looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= sw_raw;
      sync_q    <= sync_meta;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level only after a full hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sw_deb <= 1'b0;
    end else if (sync_q != sw_deb) begin
      if (cnt == DB_LAST) begin
        sw_deb <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED output register, debounced switch register,
// sticky edge-status register with write-1-to-clear, and an interrupt mask.
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int          DB_CYCLES = 16,
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              we,
  input  logic              re,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  input  logic [NUM_SW-1:0] SW,
  output logic [NUM_SW-1:0] LEDR,
  output logic              sw_irq
);

  logic [NUM_SW-1:0] led_q;
  logic [NUM_SW-1:0] mask_q;
  logic [NUM_SW-1:0] edge_q;
  logic [NUM_SW-1:0] sw_deb;
  logic [NUM_SW-1:0] sw_chg;
  logic [NUM_SW-1:0] edge_clr;
  logic              sel;
  logic [1:0]        ofs;
  logic              unused_wdata;

  assign sel = in_window(addr, BASE_ADDR);
  assign ofs = addr[1:0];

  // Upper data bits have no storage behind them.
  assign unused_wdata = ^wdata[15:NUM_SW];

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (SW[i]),
      .sw_deb (sw_deb[i]),
      .changed(sw_chg[i])
    );
  end

  assign edge_clr = (we && sel && ofs == EDGE_OFS) ? wdata[NUM_SW-1:0] : '0;

  // Processor-writable LED and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      mask_q <= '0;
    end else if (we && sel) begin
      if (ofs == LED_OFS)  led_q  <= wdata[NUM_SW-1:0];
      if (ofs == MASK_OFS) mask_q <= wdata[NUM_SW-1:0];
    end
  end

  // Sticky edge flags: a new debounced change overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | sw_chg;
    end
  end

  // Zero-wait-state read mux; a same-cycle write shows its old value here.
  always_comb begin
    rdata = 16'h0000;
    if (re && sel) begin
      case (ofs)
        LED_OFS:  rdata = {{(16-NUM_SW){1'b0}}, led_q};
        SW_OFS:   rdata = {{(16-NUM_SW){1'b0}}, sw_deb};
        EDGE_OFS: rdata = {{(16-NUM_SW){1'b0}}, edge_q};
        default:  rdata = {{(16-NUM_SW){1'b0}}, mask_q};
      endcase
    end
  end

  assign LEDR   = led_q;
  assign sw_irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio with a short debounce window.
// Inputs change 2 time units after a rising edge; outputs are sampled on the falling edge.
module tb_mmio_gpio;

  localparam int DB = 4;

  logic        stim_clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        we;
  logic        re;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        sw_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [9:0]  exp_ledr;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] rd;
    logic [9:0]  led;
    logic        irq;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb_q[$];

  mmio_gpio #(
    .DB_CYCLES(DB),
    .BASE_ADDR(16'hC000)
  ) dut (
    .clk   (stim_clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .SW    (SW),
    .LEDR  (LEDR),
    .sw_irq(sw_irq)
  );

  initial stim_clk = 1'b0;
  always #5 stim_clk = ~stim_clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    we    = w;
    re    = r;
    addr  = a;
    wdata = d;
  endtask

  task automatic tick();
    @(posedge stim_clk);
    #2;
  endtask

  task automatic push_exp(input string name, input logic [15:0] rd, input logic [9:0] led, input logic irq);
    sb_t e;
    e.name = name;
    e.rd   = rd;
    e.led  = led;
    e.irq  = irq;
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      check_output({e.name, ".rdata"}, rdata, e.rd);
      check_output({e.name, ".ledr"}, {6'd0, LEDR}, {6'd0, e.led});
      check_output({e.name, ".irq"}, {15'd0, sw_irq}, {15'd0, e.irq});
    end
  endtask

  task automatic expect_now(input string name, input logic [15:0] rd, input logic [9:0] led, input logic irq);
    push_exp(name, rd, led, irq);
    pop_compare();
  endtask

  // One bus cycle: drive, sample on the falling edge, finish just after the next rising edge.
  task automatic bus_check(input string name, input logic w, input logic r, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] rd, input logic [9:0] led,
                           input logic irq);
    apply_stimulus(w, r, a, d);
    push_exp(name, rd, led, irq);
    @(negedge stim_clk);
    pop_compare();
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    SW    = 10'h000;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

    vecs[0]  = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0000, 10'h000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0000, 10'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0000, 10'h000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'hC000, 16'hFFFF, 16'h0000, 10'h000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h03FF, 10'h3FF, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'hC001, 16'hFFFF, 16'h0000, 10'h3FF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0000, 10'h3FF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'hC003, 16'hFC02, 16'h0000, 10'h3FF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0002, 10'h3FF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'hC000, 16'h0155, 16'h0000, 10'h3FF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0155, 10'h155, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'hC004, 16'h0000, 16'h0000, 10'h155, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h4000, 16'h0000, 16'h0000, 10'h155, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'hC004, 16'h0000, 16'h0000, 10'h155, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0155, 10'h155, 1'b0};

    #3;
    expect_now("in_reset", 16'h0000, 10'h000, 1'b0);
    repeat (3) @(posedge stim_clk);
    #2;
    rst_n = 1'b1;
    tick();

    $display("[TB] register table");
    for (int i = 0; i < 16; i++) begin
      bus_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_ledr, vecs[i].exp_irq);
    end

    $display("[TB] switch step latency");
    SW = 10'h001;
    apply_stimulus(1'b0, 1'b1, 16'hC001, 16'h0000);
    repeat (5) @(posedge stim_clk);
    @(negedge stim_clk);
    expect_now("step_edge5", 16'h0000, 10'h155, 1'b0);
    @(posedge stim_clk);
    @(negedge stim_clk);
    expect_now("step_edge6", 16'h0001, 10'h155, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus_check("edge_after_step", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0001, 10'h155, 1'b0);
    bus_check("edge_clr_bit0", 1'b1, 1'b0, 16'hC002, 16'h0001, 16'h0000, 10'h155, 1'b0);
    bus_check("edge_cleared", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0000, 10'h155, 1'b0);

    $display("[TB] glitch rejection");
    SW = 10'h003;
    repeat (3) tick();
    SW = 10'h001;
    repeat (8) tick();
    bus_check("glitch_sw", 1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0001, 10'h155, 1'b0);
    bus_check("glitch_edge", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0000, 10'h155, 1'b0);

    $display("[TB] interrupt and clear");
    SW = 10'h003;
    repeat (8) tick();
    bus_check("irq_sw", 1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0003, 10'h155, 1'b1);
    bus_check("irq_clr_prewrite", 1'b1, 1'b1, 16'hC002, 16'h0002, 16'h0002, 10'h155, 1'b1);
    bus_check("irq_cleared", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0000, 10'h155, 1'b0);

    $display("[TB] set beats clear");
    SW = 10'h001;
    repeat (5) tick();
    apply_stimulus(1'b1, 1'b0, 16'hC002, 16'h0002);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus_check("set_wins_edge", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0002, 10'h155, 1'b1);
    bus_check("set_wins_sw", 1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0001, 10'h155, 1'b1);

    $display("[TB] reset during debounce");
    SW = 10'h000;
    repeat (8) tick();
    SW = 10'h001;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    expect_now("rst_async", 16'h0000, 10'h000, 1'b0);
    #1;
    bus_check("rst_led", 1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0000, 10'h000, 1'b0);
    bus_check("rst_sw", 1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0000, 10'h000, 1'b0);
    bus_check("rst_edge", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0000, 10'h000, 1'b0);
    bus_check("rst_mask", 1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h000, 1'b0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 16'hC001, 16'h0000);
    repeat (5) @(posedge stim_clk);
    @(negedge stim_clk);
    expect_now("post_rst_edge5", 16'h0000, 10'h000, 1'b0);
    @(posedge stim_clk);
    @(negedge stim_clk);
    expect_now("post_rst_edge6", 16'h0001, 10'h000, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus_check("post_rst_edgereg", 1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0001, 10'h000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_gpio.md
MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 Parameter: DB_CYCLES, default 16, number of consecutive cycles a synchronized switch must hold a new level before the debounced value changes (legal range 2..65535).
REQ-002 Parameter: BASE_ADDR, default 16'hC000, base of the 4-word register window.
REQ-003 Port: clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: addr  input  16  processor data-bus address.
REQ-006 Port: we  input  1  write strobe, one cycle per write.
REQ-007 Port: re  input  1  read strobe.
REQ-008 Port: wdata  input  16  write data.
REQ-009 Port: rdata  output  16  read data; combinational; 16'h0000 when not selected.
REQ-010 Port: SW  input  10  raw asynchronous board switches.
REQ-011 Port: LEDR  output  10  board LEDs, driven directly from the LED register.
REQ-012 Port: sw_irq  output  1  high while any unmasked edge-status bit is set.

Function
REQ-013 Register map (word offsets from BASE_ADDR): +0 LED (R/W, bits 9:0), +1 SW (RO, debounced), +2 EDGE (R, write-1-to-clear), +3 IRQ_MASK (R/W, bits 9:0); all other address bits outside the window SHALL deselect the block.
REQ-014 Unused upper bits (15:10) SHALL read as 0 and ignore writes; writes to SW SHALL be ignored.
REQ-015 rdata SHALL equal the selected register whenever re=1 and addr is in the window, same cycle, no wait states.
REQ-016 Each SW bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-017 Per bit: when synchronized value differs from debounced value, a counter increments each cycle; when equal, counter clears to 0.
REQ-018 When the counter reaches DB_CYCLES-1 while still differing, the debounced bit SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-019 A pulse shorter than DB_CYCLES synchronized cycles SHALL never change the debounced value (glitch rejection).
REQ-020 Latency: a clean SW step SHALL appear in the SW register exactly 2+DB_CYCLES rising edges after the first edge that samples it.
REQ-021 Any debounced bit change (either direction) SHALL set the matching EDGE bit on the same edge the debounced bit updates.
REQ-022 EDGE write: bits written 1 clear, bits written 0 unchanged; if a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-023 sw_irq = |(EDGE & IRQ_MASK), combinational from registers (no extra latency).
REQ-024 LED register write SHALL appear on LEDR on the edge following we.
REQ-025 Simultaneous we and re to the same register: rdata SHALL show the pre-write value.

Reset
REQ-026 On rst_n low, asynchronously: LED=0, EDGE=0, IRQ_MASK=0, synchronizer flops=0, debounced=0, counters=0; hence LEDR=0, sw_irq=0.
REQ-027 Switches held high through reset SHALL debounce to 1 after release per REQ-020 and set EDGE bits.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-029 Package gpio_pkg SHALL hold register offset constants (LED_OFS, SW_OFS, EDGE_OFS, MASK_OFS), NUM_SW=10, and the default BASE_ADDR.
REQ-030 One sub-module, gpio_debounce (single bit: synchronizer, counter, debounced flop, change pulse), SHALL be instantiated NUM_SW times.
REQ-031 Target size 120-400 lines RTL total.

Verification (DB_CYCLES=4)
REQ-032 Reset, then read +0,+1,+2,+3 -> all 16'h0000, LEDR=0, sw_irq=0.
REQ-033 Write 16'hFFFF to +0 -> LEDR=10'h3FF next edge, read +0 -> 16'h03FF.
REQ-034 SW=10'h001 held -> read +1 = 16'h0000 at edge 5, 16'h0001 at edge 6; EDGE=16'h0001.
REQ-035 SW bit1 pulsed high 3 cycles -> SW register and EDGE unchanged (16'h0000).
REQ-036 IRQ_MASK=16'h0002, toggle SW bit1 -> sw_irq=1; write 16'h0002 to +2 -> EDGE bit1=0, sw_irq=0 next edge; same-cycle set+clear -> bit stays 1.
REQ-037 Assert rst_n low after 2 mismatched cycles -> all registers 0; SW still high -> SW register=1 exactly 6 edges after release.
